// File: rtl/shared_divider.sv
// Shared radix-2 restoring divider serving two clients with round-robin arbitration.
// Results are returned with a one-cycle Ready strobe; select names the owning client.
module shared_divider #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] dividend0,
    input  logic [WIDTH-1:0] divisor0,
    input  logic             req1,
    input  logic [WIDTH-1:0] dividend1,
    input  logic [WIDTH-1:0] divisor1,
    output logic             Busy,
    output logic             Ready,
    output logic             select,
    output logic [WIDTH-1:0] dividerres,
    output logic [WIDTH-1:0] remainder,
    output logic             dbz,
    output logic             debug_state
);

    // Handshake: reqN is accepted on a rising edge only while that client has
    // nothing pending; the result is valid for the single cycle Ready=1 and
    // belongs to the client named by select. Busy and Ready never overlap.

    typedef enum logic {
        IDLE = 1'b0,
        DIV  = 1'b1
    } state_t;

    state_t state, state_next;

    logic [1:0]       pending, pending_next;
    logic             last_served;
    logic [WIDTH-1:0] op_dividend0, op_divisor0;
    logic [WIDTH-1:0] op_dividend1, op_divisor1;

    // acc starts as the dividend and fills with quotient bits from the LSB side.
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic [CNT_W-1:0] cnt;
    logic             zero_div;

    logic             do_grant;
    logic             do_finish;
    logic             grant_id;
    logic [WIDTH-1:0] grant_dividend;
    logic [WIDTH-1:0] grant_divisor;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] rem_sub;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] acc_next;
    logic             q_bit;

    assign debug_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        do_grant       = 1'b0;
        do_finish      = 1'b0;
        grant_id       = 1'b0;

        rem_shift      = {rem, acc[WIDTH-1]};
        q_bit          = (rem_shift >= {1'b0, dvs});
        rem_sub        = rem_shift[WIDTH-1:0] - dvs;
        rem_next       = q_bit ? rem_sub : rem_shift[WIDTH-1:0];
        acc_next       = {acc[WIDTH-2:0], q_bit};

        case (state)
            IDLE: begin
                if (|pending) begin
                    do_grant   = 1'b1;
                    grant_id   = (&pending) ? ~last_served : pending[1];
                    state_next = DIV;
                end
            end
            DIV: begin
                if (zero_div || cnt == CNT_W'(WIDTH - 1)) begin
                    do_finish  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        grant_dividend = grant_id ? op_dividend1 : op_dividend0;
        grant_divisor  = grant_id ? op_divisor1  : op_divisor0;

        // A grant only ever clears a bit that is already set, so a same-edge
        // request from the granted client is ignored as a pending repost.
        pending_next[0] = (pending[0] | req0) & ~(do_grant & ~grant_id);
        pending_next[1] = (pending[1] | req1) & ~(do_grant & grant_id);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending      <= 2'b00;
            op_dividend0 <= '0;
            op_divisor0  <= '0;
            op_dividend1 <= '0;
            op_divisor1  <= '0;
        end else begin
            pending <= pending_next;
            if (req0 && !pending[0]) begin
                op_dividend0 <= dividend0;
                op_divisor0  <= divisor0;
            end
            if (req1 && !pending[1]) begin
                op_dividend1 <= dividend1;
                op_divisor1  <= divisor1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Busy        <= 1'b0;
            Ready       <= 1'b0;
            select      <= 1'b0;
            last_served <= 1'b1;
            dividerres  <= '0;
            remainder   <= '0;
            dbz         <= 1'b0;
            acc         <= '0;
            dvs         <= '0;
            rem         <= '0;
            cnt         <= '0;
            zero_div    <= 1'b0;
        end else begin
            Ready <= 1'b0;
            if (do_grant) begin
                select      <= grant_id;
                last_served <= grant_id;
                Busy        <= 1'b1;
                acc         <= grant_dividend;
                dvs         <= grant_divisor;
                rem         <= '0;
                cnt         <= '0;
                zero_div    <= (grant_divisor == '0);
            end else if (state == DIV) begin
                if (do_finish) begin
                    Busy  <= 1'b0;
                    Ready <= 1'b1;
                    if (zero_div) begin
                        // acc was never shifted, so it still holds the dividend.
                        dividerres <= '1;
                        remainder  <= acc;
                        dbz        <= 1'b1;
                    end else begin
                        dividerres <= acc_next;
                        remainder  <= rem_next;
                        dbz        <= 1'b0;
                    end
                end else begin
                    acc <= acc_next;
                    rem <= rem_next;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule
